// File: rtl/bitwise_not_8bit_pkg.sv
// Shared constants for the bitwise inverter slice.
package bitwise_not_8bit_pkg;

  localparam int WIDTH = 8;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

endpackage

// File: rtl/bitwise_not_8bit_if.sv
// Operand/result bundle between a producer and the inverter.
interface bitwise_not_8bit_if;
  import bitwise_not_8bit_pkg::*;

  logic [WIDTH-1:0] a;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic             y_zero;
  logic             y_ones;

  modport master (
    output a,
    output in_valid,
    input  y,
    input  y_q,
    input  out_valid,
    input  y_zero,
    input  y_ones
  );

  modport slave (
    input  a,
    input  in_valid,
    output y,
    output y_q,
    output out_valid,
    output y_zero,
    output y_ones
  );

endinterface

// File: rtl/bitwise_not_8bit_not_comb.sv
// Pure combinational inverter with all-zero/all-ones result flags.
module bitwise_not_8bit_not_comb
  import bitwise_not_8bit_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones
);

  // Plain ~ keeps X/Z on a bit visible as X on the same result bit.
  assign y      = ~a;
  assign y_zero = (y == ALL_ZEROS);
  assign y_ones = (y == ALL_ONES);

endmodule

// File: rtl/bitwise_not_8bit.sv
// Inverter top: combinational result plus a valid-qualified registered copy.
module bitwise_not_8bit
  import bitwise_not_8bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  bitwise_not_8bit_if.slave     bus
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_reg;
  logic             valid_reg;

  bitwise_not_8bit_not_comb u_not_comb (
    .a      (bus.a),
    .y      (y_comb),
    .y_zero (bus.y_zero),
    .y_ones (bus.y_ones)
  );

  // Reset clears only the registered stage; the combinational path stays live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg     <= ALL_ZEROS;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        y_reg <= y_comb;
      end
    end
  end

  assign bus.y         = y_comb;
  assign bus.y_q       = y_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_bitwise_not_8bit.sv
// Randomized self-checking bench for bitwise_not_8bit against an arithmetic model.
module tb_bitwise_not_8bit;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  // Reference state for the registered stage
  logic [7:0] exp_yq;
  logic       exp_ov;

  bitwise_not_8bit_if bus ();

  bitwise_not_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inversion of an 8-bit value is 255 minus that value.
  function automatic logic [7:0] ref_not(input logic [7:0] v);
    return 8'(9'd255 - {1'b0, v});
  endfunction

  function automatic logic ref_zero(input logic [7:0] v);
    return (v == 8'd255);
  endfunction

  function automatic logic ref_ones(input logic [7:0] v);
    return (v == 8'd0);
  endfunction

  task automatic model_edge();
    if (rst) begin
      exp_yq = 8'd0;
      exp_ov = 1'b0;
    end else begin
      exp_ov = bus.in_valid;
      if (bus.in_valid) exp_yq = ref_not(bus.a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.a = 8'h96;
    bus.in_valid = 1'b1;
    exp_yq = 8'd0;
    exp_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.y_q !== 8'd0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state y_q=%h out_valid=%b expected 00/0", bus.y_q, bus.out_valid);
    end
    checks++;
    if (bus.y !== 8'h69) begin
      fails++;
      $display("FAIL reset_comb y=%h expected 69", bus.y);
    end
  endtask

  task automatic test_comb_corners();
    bus.a = 8'hFF; #1;
    checks++;
    if (bus.y !== 8'h00 || bus.y_zero !== 1'b1 || bus.y_ones !== 1'b0) begin
      fails++;
      $display("FAIL comb_all_ones y=%h z=%b o=%b expected 00/1/0", bus.y, bus.y_zero, bus.y_ones);
    end
    bus.a = 8'h00; #1;
    checks++;
    if (bus.y !== 8'hFF || bus.y_zero !== 1'b0 || bus.y_ones !== 1'b1) begin
      fails++;
      $display("FAIL comb_all_zeros y=%h z=%b o=%b expected ff/0/1", bus.y, bus.y_zero, bus.y_ones);
    end
    bus.a = 8'hA5; #1;
    checks++;
    if (bus.y !== 8'h5A) begin
      fails++;
      $display("FAIL comb_a5 y=%h expected 5a", bus.y);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++) begin
      bus.a = 8'(i); #1;
      checks++;
      if (bus.y !== ref_not(8'(i)) || bus.y_zero !== ref_zero(8'(i)) ||
          bus.y_ones !== ref_ones(8'(i))) begin
        fails++;
        $display("FAIL sweep a=%h y=%h z=%b o=%b expected %h/%b/%b", i[7:0], bus.y,
                 bus.y_zero, bus.y_ones, ref_not(8'(i)), ref_zero(8'(i)), ref_ones(8'(i)));
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.a = 8'h3C;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'hC3 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL reg_capture y_q=%h out_valid=%b expected c3/1", bus.y_q, bus.out_valid);
    end
    @(negedge clk);
    bus.a = 8'h11;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'hC3 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reg_hold y_q=%h out_valid=%b expected c3/0", bus.y_q, bus.out_valid);
    end
    exp_yq = 8'hC3;
    exp_ov = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.a = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'hFF || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first y_q=%h out_valid=%b expected ff/1", bus.y_q, bus.out_valid);
    end
    @(negedge clk);
    bus.a = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'h00 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second y_q=%h out_valid=%b expected 00/1", bus.y_q, bus.out_valid);
    end
    exp_yq = 8'h00;
    exp_ov = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.a = 8'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.y !== ref_not(bus.a) || bus.y_zero !== ref_zero(bus.a) ||
          bus.y_ones !== ref_ones(bus.a)) begin
        fails++;
        $display("FAIL rand_comb a=%h y=%h expected %h", bus.a, bus.y, ref_not(bus.a));
      end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (bus.y_q !== exp_yq || bus.out_valid !== exp_ov) begin
        fails++;
        $display("FAIL rand_reg y_q=%h out_valid=%b expected %h/%b", bus.y_q, bus.out_valid,
                 exp_yq, exp_ov);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.a = 8'h5B;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'hA4 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset y_q=%h out_valid=%b expected a4/1", bus.y_q, bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.y_q !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset y_q=%h out_valid=%b expected 00/0", bus.y_q, bus.out_valid);
    end
    bus.a = 8'h81;
    #1;
    checks++;
    if (bus.y !== 8'h7E) begin
      fails++;
      $display("FAIL reset_tracks y=%h expected 7e", bus.y);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold y_q=%h out_valid=%b expected 00/0", bus.y_q, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.a = 8'hE7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.y_q !== 8'h18 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset y_q=%h out_valid=%b expected 18/1", bus.y_q, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_comb_corners();
    test_sweep();
    test_registered();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bitwise_not_8bit.md
Name: bitwise_not_8bit

Overview:
- 8-bit bitwise inverter used as a datapath primitive.
- Provides a combinational inverted output `y` that updates in the same delta-cycle as `a`.
- Also provides a registered copy `y_q` with a valid flag and all-zero/all-ones status flags, for pipelined consumers.
- One clock domain; asynchronous active-high reset affects only the registered outputs.

Parameters:
- WIDTH, 8, data width in bits; the block is verified at 8 only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  WIDTH  operand
- in_valid  input  1  qualifies `a` for capture into the registered stage
- y  output  WIDTH  combinational result, ~a
- y_q  output  WIDTH  registered result of ~a from the last valid capture
- out_valid  output  1  high for one cycle after each captured `in_valid`
- y_zero  output  1  combinational; high when y == 0 (i.e. a is all ones)
- y_ones  output  1  combinational; high when y is all ones (i.e. a == 0)

Behaviour:
- `y` = bitwise NOT of `a`, purely combinational, zero-cycle latency.
  - Valid even while `rst` is asserted.
  - No dependence on `clk`.
- X/Z on any bit of `a` propagates as X on the corresponding bit of `y`. No masking.
- `y_zero` = (y == 0); `y_ones` = (y == all ones). Both combinational.
- Registered stage, evaluated on the rising edge of `clk` when rst = 0:
  - If in_valid = 1: y_q <= ~a and out_valid <= 1.
  - If in_valid = 0: y_q holds its value and out_valid <= 0.
- Latency from `a` with in_valid high to `y_q`/`out_valid`: 1 cycle.
- Back-to-back valid inputs produce back-to-back outputs. Throughput is 1 per cycle; there is no backpressure.
- Reset:
  - Asserting `rst` forces y_q = 0 and out_valid = 0 immediately, asynchronously.
  - Values are held while `rst` is high.
  - Reset asserted mid-stream discards any pending capture.
  - The first capture after `rst` deasserts happens on the next rising edge with in_valid = 1.
- Simultaneous change of `a` and a rising clock edge: the capture uses the value of `a` sampled at the edge. `y` reflects the new `a` immediately.

Decomposition:
- Shared package: WIDTH default constant (8) and the all-ones constant derived from WIDTH.
- One natural sub-module, `not_comb`: the pure combinational inverter plus the zero/ones flags.
- The top level adds the valid-qualified output register and reset logic around `not_comb`.

Test Plan:
- Combinational, all ones: a = 8'b11111111 (no clock needed) -> y = 8'b00000000, y_zero = 1, y_ones = 0.
- Combinational, all zeros: a = 8'b00000000 -> y = 8'b11111111, y_zero = 0, y_ones = 1.
- Exhaustive sweep: a = 0..255 -> y == ~a for every value, checked with case equality. Also a = 8'hA5 -> y = 8'h5A.
- Registered path:
  - After reset release, drive a = 8'h3C with in_valid = 1 for one cycle -> next cycle y_q = 8'hC3, out_valid = 1.
  - The cycle after that (in_valid = 0) -> out_valid = 0, y_q holds 8'hC3.
- Back-to-back: a = 8'h00 then 8'hFF on consecutive valid cycles -> y_q = 8'hFF then 8'h00 on consecutive cycles, out_valid high for both.
- Async reset mid-operation:
  - Assert rst between clock edges while out_valid = 1 -> y_q = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - `y` still tracks ~a while rst is high.
